// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared channel geometry and scan FSM states for the ADC scan sequencer
package adc_seq_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W = 3;
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, START, WAIT, STORE} state_t;
endpackage

// File: rtl/lowest_bit_sel.sv
// lowest_bit_sel: priority encoder returning the lowest set bit of a channel mask
module lowest_bit_sel
  import adc_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  output logic [CH_W-1:0]   idx,
  output logic              any
);
  always_comb begin
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (mask[i]) idx = CH_W'(i);
  end
  assign any = |mask;
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: converts each enabled ADC channel in ascending order once per sample_tick
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] channel_mask,
  input  logic              sample_tick,
  input  logic              clear_flags,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_data,
  output logic              spi_start,
  output logic [CH_W-1:0]   spi_channel,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic              round_done,
  output logic              overrun,
  output logic              timeout_err,
  output logic [NUM_CH-1:0] led
);
  localparam int MAX_CNT = SETTLE_CYCLES > TIMEOUT_CYCLES ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(MAX_CNT + 1);
  state_t            state;
  logic [NUM_CH-1:0] round_mask;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   low_idx;
  logic              low_any;
  lowest_bit_sel u_sel (.mask(round_mask), .idx(low_idx), .any(low_any));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      round_mask <= '0;
      cnt <= '0;
      spi_start <= 1'b0;
      spi_channel <= '0;
      sample_valid <= 1'b0;
      sample_ch <= '0;
      sample_data <= '0;
      round_done <= 1'b0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
      led <= '0;
    end else begin
      spi_start <= 1'b0;
      sample_valid <= 1'b0;
      round_done <= 1'b0;
      led <= (state inside {SETTLE, START, WAIT, STORE}) ? NUM_CH'(1) << spi_channel : channel_mask;
      if (clear_flags) begin
        overrun <= 1'b0;
        timeout_err <= 1'b0;
      end
      // later assignment wins, so a same-cycle set beats clear_flags
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE:
          if (sample_tick && scan_en && |channel_mask) begin
            round_mask <= channel_mask;
            state <= SELECT;
          end
        SELECT:
          if (!scan_en) state <= IDLE;
          else if (!low_any) begin
            round_done <= 1'b1;
            state <= IDLE;
          end else begin
            spi_channel <= low_idx;
            cnt <= '0;
            state <= SETTLE;
          end
        SETTLE:
          if (!scan_en) state <= IDLE;
          else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt <= '0;
            state <= START;
          end else cnt <= cnt + 1'b1;
        START:
          if (!spi_busy) begin
            spi_start <= 1'b1;
            cnt <= '0;
            state <= WAIT;
          end
        WAIT:
          if (spi_done) begin
            sample_valid <= 1'b1;
            sample_ch <= spi_channel;
            sample_data <= spi_data;
            state <= STORE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            round_mask[spi_channel] <= 1'b0;
            state <= SELECT;
          end else cnt <= cnt + 1'b1;
        STORE: begin
          round_mask[spi_channel] <= 1'b0;
          state <= SELECT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed checks of scan order, timing, flags, aborts and reset
module tb_adc_scan_sequencer;
  logic        clk = 0, reset = 1, scan_en = 0, sample_tick = 0, clear_flags = 0;
  logic        spi_busy = 0, spi_done = 0;
  logic [7:0]  channel_mask = 0;
  logic [11:0] spi_data = 0;
  logic        spi_start, sample_valid, round_done, overrun, timeout_err;
  logic [2:0]  spi_channel, sample_ch;
  logic [11:0] sample_data;
  logic [7:0]  led;
  int n_vec = 0, n_err = 0;

  adc_scan_sequencer dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .channel_mask(channel_mask),
    .sample_tick(sample_tick), .clear_flags(clear_flags), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_data(spi_data), .spi_start(spi_start),
    .spi_channel(spi_channel), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .round_done(round_done), .overrun(overrun),
    .timeout_err(timeout_err), .led(led)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    sample_tick = 1;
    step();
    sample_tick = 0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!spi_start && n < 300) begin
      step();
      n++;
    end
    chk("spi_start_seen", 32'(spi_start), 1);
  endtask

  task automatic conv(input logic [2:0] ch, input logic [11:0] d);
    wait_start();
    chk("spi_channel", 32'(spi_channel), 32'(ch));
    repeat (20) step();
    spi_done = 1;
    spi_data = d;
    step();
    spi_done = 0;
    chk("sample_valid", 32'(sample_valid), 1);
    chk("sample_ch", 32'(sample_ch), 32'(ch));
    chk("sample_data", 32'(sample_data), 32'(d));
    step();
    chk("sample_valid_pulse", 32'(sample_valid), 0);
  endtask

  initial begin
    bit seen;
    repeat (3) step();
    chk("reset_outputs", {spi_start, spi_channel, sample_valid, sample_ch, sample_data,
                          round_done, overrun, timeout_err, led}, 0);
    reset = 0;
    scan_en = 1;
    channel_mask = 8'b0010_0101;
    step();
    // round over channels 0,2,5 with exact start latency
    tick();
    step();
    step();
    step();
    chk("led_onehot_ch0", 32'(led), 32'h01);
    repeat (14) step();
    chk("start_not_before_k18", 32'(spi_start), 0);
    step();
    chk("start_at_k18", 32'(spi_start), 1);
    conv(3'd0, 12'hA11);
    conv(3'd2, 12'h5C2);
    chk("no_round_done_early", 32'(round_done), 0);
    conv(3'd5, 12'hFFF);
    step();
    chk("round_done", 32'(round_done), 1);
    step();
    chk("round_done_pulse", 32'(round_done), 0);
    // busy delays start by 5; mask change mid-round waits for next round
    channel_mask = 8'h01;
    spi_busy = 1;
    step();
    tick();
    channel_mask = 8'h80;
    repeat (18) step();
    chk("busy_hold_k18", 32'(spi_start), 0);
    repeat (4) step();
    chk("busy_hold_k22", 32'(spi_start), 0);
    spi_busy = 0;
    step();
    chk("busy_release_k23", 32'(spi_start), 1);
    conv(3'd0, 12'h123);
    step();
    chk("round_done_ch0_only", 32'(round_done), 1);
    // next round picks up ch7; overrun set/clear precedence
    step();
    tick();
    step();
    sample_tick = 1;
    step();
    sample_tick = 0;
    chk("overrun_set", 32'(overrun), 1);
    sample_tick = 1;
    clear_flags = 1;
    step();
    sample_tick = 0;
    chk("overrun_set_wins", 32'(overrun), 1);
    step();
    clear_flags = 0;
    chk("overrun_cleared", 32'(overrun), 0);
    conv(3'd7, 12'h777);
    step();
    chk("round_done_ch7", 32'(round_done), 1);
    // ch3 never answers: timeout after exactly TIMEOUT_CYCLES in WAIT
    channel_mask = 8'h0C;
    step();
    tick();
    conv(3'd2, 12'h2A2);
    wait_start();
    chk("timeout_ch", 32'(spi_channel), 3);
    seen = 0;
    for (int i = 0; i < 1023; i++) begin
      step();
      if (sample_valid) seen = 1;
    end
    chk("timeout_not_early", 32'(timeout_err), 0);
    step();
    chk("timeout_err", 32'(timeout_err), 1);
    chk("no_sample_ch3", 32'(seen), 0);
    step();
    chk("round_done_after_timeout", 32'(round_done), 1);
    clear_flags = 1;
    step();
    clear_flags = 0;
    chk("timeout_cleared", 32'(timeout_err), 0);
    // scan_en low in SETTLE aborts without start or round_done
    tick();
    step();
    step();
    chk("led_settle_ch2", 32'(led), 32'h04);
    scan_en = 0;
    step();
    step();
    chk("led_mask_after_abort", 32'(led), 32'h0C);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (spi_start || round_done) seen = 1;
    end
    chk("abort_quiet", 32'(seen), 0);
    // async reset during WAIT
    scan_en = 1;
    channel_mask = 8'h10;
    tick();
    step();
    sample_tick = 1;
    step();
    sample_tick = 0;
    wait_start();
    repeat (3) step();
    chk("pre_reset_led", 32'(led), 32'h10);
    reset = 1;
    #2;
    chk("async_reset_outputs", {spi_start, spi_channel, sample_valid, sample_ch, sample_data,
                                round_done, overrun, timeout_err, led}, 0);
    step();
    reset = 0;
    step();
    step();
    chk("post_reset_idle_led", 32'(led), 32'h10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
